// File: rtl/clmul_seq_unit_if.sv
// Issue/result handshake bundle for the sequential carry-less multiply unit.
// The op field is carried as raw bits and typed inside the unit.
interface clmul_seq_unit_if #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned OP_W  = 5
);
    logic             in_valid_i;
    logic             in_ready_o;
    logic [OP_W-1:0]  op_i;
    logic [WIDTH-1:0] rs1_i;
    logic [WIDTH-1:0] rs2_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [WIDTH-1:0] result_o;
    logic             illegal_o;

    modport master (
        output in_valid_i, op_i, rs1_i, rs2_i, out_ready_i,
        input  in_ready_o, out_valid_o, result_o, illegal_o
    );

    modport slave (
        input  in_valid_i, op_i, rs1_i, rs2_i, out_ready_i,
        output in_ready_o, out_valid_o, result_o, illegal_o
    );
endinterface

// File: rtl/clmul_seq_unit.sv
// Multi-cycle carry-less multiply (CLMUL/CLMULH/CLMULR), one multiplier bit per
// cycle with early exit once the remaining multiplier bits are all zero.
package riscv_pkg;
    localparam int unsigned WIDTH = 64;

    typedef enum logic [4:0] {
        ALU_ADD, ALU_SUB, ALU_XOR, ALU_OR, ALU_AND, ALU_SLL, ALU_SRL, ALU_SRA,
        ALU_SLT, ALU_SLTU, ALU_CLMUL, ALU_CLMULH, ALU_CLMULR
    } op_alu_e;
endpackage

module clmul_seq_unit #(
    parameter int unsigned WIDTH = riscv_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    clmul_seq_unit_if.slave  bus
);
    import riscv_pkg::*;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         r_state, w_state_d;
    logic [2*WIDTH-1:0] r_a, w_a_d;
    logic [WIDTH-1:0]   r_b, w_b_d;
    logic [2*WIDTH-1:0] r_acc, w_acc_d;
    op_alu_e            r_op, w_op_d;
    logic [WIDTH-1:0]   r_result, w_result_d;
    logic               r_illegal, w_illegal_d;

    op_alu_e            w_op_in;
    logic               w_is_clmul;
    logic [2*WIDTH-1:0] w_acc_x;
    logic [WIDTH-1:0]   w_b_sh;
    logic [WIDTH-1:0]   w_sel;

    assign w_op_in    = op_alu_e'(bus.op_i);
    assign w_is_clmul = (w_op_in == ALU_CLMUL) || (w_op_in == ALU_CLMULH) ||
                        (w_op_in == ALU_CLMULR);
    // This cycle's partial product is folded in before the exit test.
    assign w_acc_x    = r_b[0] ? (r_acc ^ r_a) : r_acc;
    assign w_b_sh     = r_b >> 1;

    always_comb begin
        unique case (r_op)
            ALU_CLMULH: w_sel = w_acc_x[2*WIDTH-1:WIDTH];
            ALU_CLMULR: w_sel = w_acc_x[2*WIDTH-2:WIDTH-1];
            default:    w_sel = w_acc_x[WIDTH-1:0];
        endcase
    end

    always_comb begin
        w_state_d   = r_state;
        w_a_d       = r_a;
        w_b_d       = r_b;
        w_acc_d     = r_acc;
        w_op_d      = r_op;
        w_result_d  = r_result;
        w_illegal_d = r_illegal;
        if (flush_i) begin
            w_state_d = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid_i) begin
                        if (w_is_clmul) begin
                            w_a_d     = {{WIDTH{1'b0}}, bus.rs1_i};
                            w_b_d     = bus.rs2_i;
                            w_acc_d   = '0;
                            w_op_d    = w_op_in;
                            w_state_d = S_BUSY;
                        end else begin
                            w_result_d  = '0;
                            w_illegal_d = 1'b1;
                            w_state_d   = S_DONE;
                        end
                    end
                end
                S_BUSY: begin
                    w_a_d   = r_a << 1;
                    w_b_d   = w_b_sh;
                    w_acc_d = w_acc_x;
                    if (w_b_sh == '0) begin
                        w_result_d  = w_sel;
                        w_illegal_d = 1'b0;
                        w_state_d   = S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready_i) w_state_d = S_IDLE;
                end
                default: w_state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_acc     <= '0;
            r_op      <= ALU_CLMUL;
            r_result  <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_a       <= w_a_d;
            r_b       <= w_b_d;
            r_acc     <= w_acc_d;
            r_op      <= w_op_d;
            r_result  <= w_result_d;
            r_illegal <= w_illegal_d;
        end
    end

    assign bus.in_ready_o  = (r_state == S_IDLE);
    assign bus.out_valid_o = (r_state == S_DONE);
    assign bus.result_o    = r_result;
    assign bus.illegal_o   = r_illegal;
endmodule
